// File: rtl/hough_vote_engine_if.sv
// ============================================================================
// hough_vote_engine_if : edge-image stream, trig-unit and accumulator-RAM bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface hough_vote_engine_if #(
    parameter int DATA_W = 240,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int T_W    = 8,
    parameter int ADDR_W = 11,
    parameter int ACC_W  = 16
);
    logic              start;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              data_ready;
    logic [X_W-1:0]    x_address;
    logic [Y_W-1:0]    y_address;
    logic [T_W-1:0]    theta;
    logic [ADDR_W:0]   hough_result;
    logic [ADDR_W-1:0] acc_rd_addr;
    logic [ACC_W-1:0]  acc_rd_data;
    logic              acc_wr_en;
    logic [ADDR_W-1:0] acc_wr_addr;
    logic [ACC_W-1:0]  acc_wr_data;

    modport master (
        output start, valid, data, hough_result, acc_rd_data,
        input  data_ready, x_address, y_address, theta,
               acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data
    );

    modport slave (
        input  start, valid, data, hough_result, acc_rd_data,
        output data_ready, x_address, y_address, theta,
               acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data
    );
endinterface

`default_nettype wire

// File: rtl/hough_vote_engine.sv
// ============================================================================
// hough_vote_engine : buffers a binary edge frame, clears the accumulator and
// casts saturating Hough votes for every edge pixel across all theta steps.
// Rev 1.0
// ============================================================================
`default_nettype none

module hough_vote_engine #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int DATA_W      = 240,
    parameter int THETA_STEPS = 180,
    parameter int RHO_OFFSET  = 800,
    parameter int ACC_DEPTH   = 1601,
    parameter int ACC_W       = 16,
    parameter int ADDR_W      = 11,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int T_W         = 8
) (
    input  wire logic                             clk,
    input  wire logic                             rst_n,
    hough_vote_engine_if.slave                    bus,
    output logic                                  o_busy,
    output logic                                  o_ready,
    output logic                                  o_rho_err,
    output logic                                  o_sat_flag,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0]      o_edge_count
);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NBEATS = NPIX / DATA_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W  = $clog2(NPIX + 1);

    localparam logic [BEAT_W-1:0]        c_LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [BIT_W-1:0]         c_LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [X_W-1:0]           c_LAST_X    = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]           c_LAST_Y    = Y_W'(IMG_H - 1);
    localparam logic [T_W-1:0]           c_LAST_T    = T_W'(THETA_STEPS - 1);
    localparam logic [ADDR_W-1:0]        c_LAST_ADDR = ADDR_W'(ACC_DEPTH - 1);
    localparam logic signed [ADDR_W+1:0] c_OFFSET    = (ADDR_W+2)'(RHO_OFFSET);
    localparam logic signed [ADDR_W+1:0] c_DEPTH     = (ADDR_W+2)'(ACC_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLEAR     = 4'd1,
        S_LOAD      = 4'd2,
        S_SCAN_RD   = 4'd3,
        S_SCAN_CHK  = 4'd4,
        S_VOTE_CALC = 4'd5,
        S_VOTE_RD   = 4'd6,
        S_VOTE_WR   = 4'd7,
        S_VOTE_NEXT = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t              r_state, w_next, w_adv_next;
    logic [ADDR_W-1:0]   r_clr_addr, r_addr;
    logic [BEAT_W-1:0]   r_beat, r_word;
    logic [BIT_W-1:0]    r_bit;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [T_W-1:0]      r_theta;
    logic [CNT_W-1:0]    r_edge_count;
    logic                r_rho_err, r_sat;
    logic [DATA_W-1:0]   r_buf [NBEATS];
    logic [DATA_W-1:0]   r_rd_word;

    logic                     w_beat_ok, w_last_pix, w_bit_wrap, w_cur_bit;
    logic                     w_advance, w_in_range, w_sat_hit, w_start;
    logic signed [ADDR_W+1:0] w_rho_ext, w_addr_s;

    assign w_start    = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_beat_ok  = (r_state == S_LOAD) && bus.valid;
    assign w_last_pix = (r_x == c_LAST_X) && (r_y == c_LAST_Y);
    assign w_bit_wrap = (r_bit == c_LAST_BIT);
    assign w_cur_bit  = r_rd_word[r_bit];
    assign w_sat_hit  = &bus.acc_rd_data;
    assign w_adv_next = w_last_pix ? S_DONE : (w_bit_wrap ? S_SCAN_RD : S_SCAN_CHK);

    // Sign-extend rho one extra bit so that rho + offset can never wrap.
    assign w_rho_ext  = {bus.hough_result[ADDR_W], bus.hough_result};
    assign w_addr_s   = w_rho_ext + c_OFFSET;
    assign w_in_range = !w_addr_s[ADDR_W+1] && (w_addr_s < c_DEPTH);

    assign bus.x_address = r_x;
    assign bus.y_address = r_y;
    assign bus.theta     = r_theta;
    assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_ready       = (r_state == S_DONE);
    assign o_rho_err     = r_rho_err;
    assign o_sat_flag    = r_sat;
    assign o_edge_count  = r_edge_count;

    always_comb begin
        w_next          = r_state;
        w_advance       = 1'b0;
        bus.data_ready  = 1'b0;
        bus.acc_rd_addr = '0;
        bus.acc_wr_en   = 1'b0;
        bus.acc_wr_addr = '0;
        bus.acc_wr_data = '0;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start) w_next = S_CLEAR;
            S_CLEAR: begin
                bus.acc_wr_en   = 1'b1;
                bus.acc_wr_addr = r_clr_addr;
                if (r_clr_addr == c_LAST_ADDR) w_next = S_LOAD;
            end
            S_LOAD: begin
                bus.data_ready = 1'b1;
                if (bus.valid && r_beat == c_LAST_BEAT) w_next = S_SCAN_RD;
            end
            S_SCAN_RD: w_next = S_SCAN_CHK;
            S_SCAN_CHK: begin
                if (w_cur_bit) begin
                    w_next = S_VOTE_CALC;
                end else begin
                    w_advance = 1'b1;
                    w_next    = w_adv_next;
                end
            end
            S_VOTE_CALC: w_next = S_VOTE_RD;
            S_VOTE_RD: begin
                if (w_in_range) begin
                    bus.acc_rd_addr = w_addr_s[ADDR_W-1:0];
                    w_next          = S_VOTE_WR;
                end else begin
                    w_next = S_VOTE_NEXT;
                end
            end
            S_VOTE_WR: begin
                bus.acc_wr_en   = 1'b1;
                bus.acc_wr_addr = r_addr;
                bus.acc_wr_data = w_sat_hit ? bus.acc_rd_data : bus.acc_rd_data + 1'b1;
                w_next          = S_VOTE_NEXT;
            end
            S_VOTE_NEXT: begin
                if (r_theta == c_LAST_T) begin
                    w_advance = 1'b1;
                    w_next    = w_adv_next;
                end else begin
                    w_next = S_VOTE_CALC;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_clr_addr   <= '0;
            r_addr       <= '0;
            r_beat       <= '0;
            r_word       <= '0;
            r_bit        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_theta      <= '0;
            r_edge_count <= '0;
            r_rho_err    <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_clr_addr   <= '0;
                r_beat       <= '0;
                r_word       <= '0;
                r_bit        <= '0;
                r_x          <= '0;
                r_y          <= '0;
                r_theta      <= '0;
                r_edge_count <= '0;
                r_rho_err    <= 1'b0;
                r_sat        <= 1'b0;
            end
            if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
            if (w_beat_ok) r_beat <= r_beat + 1'b1;
            if (r_state == S_SCAN_CHK && w_cur_bit) begin
                r_edge_count <= r_edge_count + 1'b1;
                r_theta      <= '0;
            end
            if (r_state == S_VOTE_RD) begin
                if (w_in_range) r_addr <= w_addr_s[ADDR_W-1:0];
                else            r_rho_err <= 1'b1;
            end
            if (r_state == S_VOTE_WR && w_sat_hit) r_sat <= 1'b1;
            if (r_state == S_VOTE_NEXT && r_theta != c_LAST_T) r_theta <= r_theta + 1'b1;
            // Pixel walk: raster order, with the bit pointer tracking the buffer word.
            if (w_advance && !w_last_pix) begin
                if (r_x == c_LAST_X) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
                if (w_bit_wrap) begin
                    r_bit  <= '0;
                    r_word <= r_word + 1'b1;
                end else begin
                    r_bit <= r_bit + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat_ok) r_buf[r_beat] <= bus.data;
        if (r_state == S_SCAN_RD) r_rd_word <= r_buf[r_word];
    end
endmodule

`default_nettype wire

// File: tb/tb_hough_vote_engine.sv
// ============================================================================
// tb_hough_vote_engine : scoreboard bench with trig and accumulator-RAM models
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hough_vote_engine;
    localparam int IMG_W = 8, IMG_H = 4, DATA_W = 8, THETA_STEPS = 4;
    localparam int RHO_OFFSET = 8, ACC_DEPTH = 32, ACC_W = 2, ADDR_W = 5;
    localparam int X_W = 3, Y_W = 2, T_W = 2;
    localparam int NPIX = IMG_W * IMG_H, NBEATS = NPIX / DATA_W;

    typedef struct {
        int                         edges;
        int                         rho_err;
        int                         sat;
        int                         writes;
        int                         busy;
        logic [ACC_DEPTH*ACC_W-1:0] acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, ready, rho_err, sat_flag;
    logic [5:0] edge_count;
    logic fill_req = 1'b1;
    int   trig_mode = 0;
    logic [ACC_W-1:0] acc_mem [ACC_DEPTH];
    exp_t sb_q[$];
    int   n_checks = 0, n_errors = 0;
    int   busy_cyc = 0, beats = 0, clr_wr = 0, vote_wr = 0;
    logic loaded = 1'b0, prev_busy = 1'b0;

    hough_vote_engine_if #(.DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W), .T_W(T_W),
                           .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus ();

    hough_vote_engine #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .THETA_STEPS(THETA_STEPS),
        .RHO_OFFSET(RHO_OFFSET), .ACC_DEPTH(ACC_DEPTH), .ACC_W(ACC_W),
        .ADDR_W(ADDR_W), .X_W(X_W), .Y_W(Y_W), .T_W(T_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .o_busy(busy), .o_ready(ready), .o_rho_err(rho_err),
        .o_sat_flag(sat_flag), .o_edge_count(edge_count)
    );

    always #5 clk = ~clk;

    function automatic int rho_fn(input int mode, input int x, input int t);
        if (mode == 1 && t == 2) return -20;
        return x + t;
    endfunction

    // Trig unit (1-cycle latency) and accumulator RAM (1-cycle read latency).
    always @(posedge clk) begin
        bus.hough_result <= (ADDR_W+1)'(rho_fn(trig_mode, int'(bus.x_address), int'(bus.theta)));
        bus.acc_rd_data  <= acc_mem[bus.acc_rd_addr];
        if (fill_req) begin
            for (int i = 0; i < ACC_DEPTH; i++) acc_mem[i] <= '1;
        end else if (bus.acc_wr_en) begin
            acc_mem[bus.acc_wr_addr] <= bus.acc_wr_data;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            prev_busy <= 1'b0;
        end else begin
            prev_busy <= busy;
            if (busy && !prev_busy) begin
                busy_cyc <= 1;
                beats    <= 0;
                loaded   <= 1'b0;
                clr_wr   <= bus.acc_wr_en ? 1 : 0;
                vote_wr  <= 0;
            end else begin
                if (busy) busy_cyc <= busy_cyc + 1;
                if (bus.valid && bus.data_ready) begin
                    beats  <= beats + 1;
                    loaded <= 1'b1;
                end
                if (bus.acc_wr_en) begin
                    if (loaded) vote_wr <= vote_wr + 1;
                    else        clr_wr  <= clr_wr + 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [NPIX-1:0] img, input int mode, input int gap_sum);
        exp_t e;
        int   a, cnt;
        e.edges = 0; e.rho_err = 0; e.sat = 0; e.writes = 0; e.acc = '0;
        e.busy = ACC_DEPTH + gap_sum + NBEATS + NBEATS + NPIX;
        for (int p = 0; p < NPIX; p++) begin
            if (img[p]) begin
                e.edges++;
                for (int t = 0; t < THETA_STEPS; t++) begin
                    a = rho_fn(mode, p % IMG_W, t) + RHO_OFFSET;
                    if (a >= 0 && a < ACC_DEPTH) begin
                        e.writes++;
                        e.busy += 4;
                        cnt = int'(e.acc[a*ACC_W +: ACC_W]);
                        if (cnt == (1 << ACC_W) - 1) e.sat = 1;
                        else e.acc[a*ACC_W +: ACC_W] = ACC_W'(cnt + 1);
                    end else begin
                        e.rho_err = 1;
                        e.busy += 3;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic start_and_load(input logic [NPIX-1:0] img, input logic [15:0] gaps);
        int w;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.valid = 1'b1;
        check_eq("start_busy", busy, 1);
        check_eq("start_ready", ready, 0);
        check_eq("start_rho_err", rho_err, 0);
        check_eq("start_sat", sat_flag, 0);
        check_eq("start_edges", edge_count, 0);
        w = 0;
        while (!bus.data_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check_eq("load_timeout", 0, 1);
        for (int k = 0; k < NBEATS; k++) begin
            for (int g = 0; g < int'(gaps[k*4 +: 4]); g++) begin
                bus.valid = 1'b0;
                @(negedge clk);
            end
            bus.valid = 1'b1;
            bus.data  = img[k*DATA_W +: DATA_W];
            @(negedge clk);
        end
        bus.data = '1;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic run_frame(input logic [NPIX-1:0] img, input int mode, input logic [15:0] gaps);
        int   w, gs;
        exp_t e;
        gs = 0;
        for (int k = 0; k < NBEATS; k++) gs += int'(gaps[k*4 +: 4]);
        trig_mode = mode;
        sb_q.push_back(model(img, mode, gs));
        start_and_load(img, gaps);
        w = 0;
        while (!ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) check_eq("ready_timeout", 0, 1);
        e = sb_q.pop_front();
        check_eq("busy_in_done", busy, 0);
        check_eq("edge_count", edge_count, e.edges);
        check_eq("rho_err", rho_err, e.rho_err);
        check_eq("sat_flag", sat_flag, e.sat);
        check_eq("beats", beats, NBEATS);
        check_eq("clear_writes", clr_wr, ACC_DEPTH);
        check_eq("vote_writes", vote_wr, e.writes);
        check_eq("busy_cycles", busy_cyc, e.busy);
        for (int i = 0; i < ACC_DEPTH; i++)
            check_eq($sformatf("acc[%0d]", i), acc_mem[i], e.acc[i*ACC_W +: ACC_W]);
        @(negedge clk);
        check_eq("ready_hold", ready, 1);
    endtask

    initial begin
        int w;
        bus.start = 1'b0;
        bus.valid = 1'b0;
        bus.data  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wr_en", bus.acc_wr_en, 0);
        fill_req = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", ready, 0);
        check_eq("idle_data_ready", bus.data_ready, 0);
        check_eq("idle_edges", edge_count, 0);

        run_frame(32'h0000_0000, 0, 16'h3201);
        run_frame(32'h0008_0000, 0, 16'h0000);
        run_frame(32'h0008_0800, 0, 16'h0102);
        run_frame(32'h2020_2020, 0, 16'h0000);
        run_frame(32'h0008_0000, 1, 16'h0010);

        // Abort a frame in the middle of its first vote write.
        trig_mode = 0;
        start_and_load(32'h0008_0000, 16'h0000);
        w = 0;
        while (!bus.acc_wr_en && w < 500) begin
            @(negedge clk);
            w++;
        end
        check_eq("vote_wr_seen", bus.acc_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_wr_en", bus.acc_wr_en, 0);
        check_eq("abort_busy", busy, 0);
        @(negedge clk);
        check_eq("abort_wr_en_next", bus.acc_wr_en, 0);
        check_eq("abort_ready", ready, 0);
        check_eq("abort_flags", {rho_err, sat_flag}, 0);
        check_eq("abort_edges", edge_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(32'h0000_0000, 0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
